pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage 16-bit pipeline: PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards and handles taken-branch flushes.
- Sequences the handshake to the data memory behind the EX_MEM register.
- Drives per-stage stall (hold) and flush (insert bubble) enables for every pipeline register.

Parameters:
- REG_ADDR_W, 3, register index width (matches instruction register field).
- MEM_TIMEOUT, 15, max WAIT cycles before abort (only used with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_reg1_i  in  REG_ADDR_W  source reg 1 of instruction in ID.
- id_reg2_i  in  REG_ADDR_W  source reg 2 of instruction in ID.
- id_reg1Read_i  in  1  ID instruction reads reg1.
- id_reg2Read_i  in  1  ID instruction reads reg2.
- ex_memRead_i  in  1  EX instruction is a load.
- ex_reg3_i  in  REG_ADDR_W  destination reg of EX instruction.
- ex_branchTaken_i  in  1  branch resolved taken in EX.
- mem_memRead_i  in  1  MEM-stage load.
- mem_memWrite_i  in  1  MEM-stage store.
- dmem_ack_i  in  1  data memory completion, one-cycle pulse.
- dmem_req_o  out  1  registered memory request.
- stall_o  out  5  hold enables; bit0=PC, 1=IF_ID, 2=ID_EX, 3=EX_MEM, 4=MEM_WB.
- flush_o  out  5  bubble enables, same bit order. A flushed register loads all-zero control.
- dmem_err_o  out  1  sticky timeout error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_i low, async):
  - State IDLE; dmem_req_o=0, dmem_err_o=0, wait counter=0.
  - stall_o and flush_o forced to 0 while rst_i is low.
- Memory FSM, registered, states IDLE, WAIT, DONE:
  - IDLE:
    - If mem_memRead_i|mem_memWrite_i: next WAIT; dmem_req_o<=1.
    - Stall is asserted combinationally in this same cycle, so the access never escapes early.
  - WAIT:
    - dmem_req_o held 1.
    - On dmem_ack_i: next DONE, dmem_req_o<=0.
  - DONE:
    - One cycle. No request is issued, even though the completed instruction is still in MEM.
    - Next state IDLE unconditionally.
  - An ack arriving in IDLE or DONE is ignored.
- mem_stall = (IDLE & access) | WAIT.
  - Drives stall_o[3:0]=1111 and flush_o[4]=1, so MEM_WB receives a bubble.
  - Drives stall_o[4]=0.
- Load-use: load_use = ex_memRead_i & ((id_reg1Read_i & id_reg1_i==ex_reg3_i) | (id_reg2Read_i & id_reg2_i==ex_reg3_i)).
  - No register index is exempt; R0 is treated as a real register.
  - Response: stall_o[1:0]=11 and flush_o[2]=1.
  - Penalty is exactly one cycle: the load has moved on to MEM the next cycle, so load_use deasserts.
- Branch: ex_branchTaken_i gives flush_o[2:1]=11. PC is reloaded by the fetch logic and is not stalled.
- Priority: mem_stall > branch > load_use.
  - During mem_stall, branch and load-use produce no outputs. Their inputs stay frozen and act in the first non-stalled cycle.
  - Branch suppresses load_use, because the ID instruction is being flushed.
- Stall and flush are never both set on the same bit.
- No latency beyond the above: hazard outputs are combinational from inputs and FSM state.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_TIMEOUT_EN.
- Defined:
  - 4-bit wait counter cleared on entering WAIT, incremented each WAIT cycle.
  - When the counter reaches MEM_TIMEOUT without ack: next DONE, dmem_req_o<=0, dmem_err_o<=1.
  - dmem_err_o is sticky until reset.
  - Ack and timeout in the same cycle: ack wins, no error.
- Undefined: no counter; WAIT lasts until ack indefinitely; dmem_err_o tied 0.

Decomposition:
- Shared defines header: stage bit indices (STG_PC..STG_MEM_WB), FSM state encodings (2-bit), reset-active level constant for active-low reset.
- One natural sub-module, hazard_detect: the combinational load-use comparator. FSM, priority and output muxing stay in the top.

Test Plan:
- Reset: drive rst_i=0 mid-WAIT (asynchronous to clock) -> dmem_req_o=0, stall_o=00000, flush_o=00000 immediately; after release, state IDLE.
- Load-use: ex_memRead_i=1, ex_reg3_i=3, id_reg2_i=3, id_reg2Read_i=1 -> exactly one cycle of stall_o=00011, flush_o=00100.
- Memory access: mem_memRead_i=1, ack 4 cycles after req:
  - stall_o=01111 and flush_o=10000 for 5 cycles; dmem_req_o high 4 cycles.
  - DONE cycle gives stall_o=0; no second request.
- Branch with concurrent load-use: ex_branchTaken_i=1 and load-use condition both true -> flush_o=00110, stall_o=00000.
- Branch during mem_stall: branch held until ack -> flush_o=00110 in the DONE cycle, not earlier.
- Timeout (macro defined, MEM_TIMEOUT=15): never ack -> after 15 WAIT cycles FSM reaches DONE, dmem_err_o=1 and stays 1; with ack on cycle 15, dmem_err_o=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: stage bit indices, memory FSM encodings, reset level and stall/flush masks
package pipe_hazard_ctrl_pkg;
  localparam int STG_PC = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam logic RST_ACTIVE = 1'b0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic logic [4:0] stg(input int i);
    return 5'(1) << i;
  endfunction
  localparam logic [4:0] MEM_STALL = stg(STG_PC) | stg(STG_IF_ID) | stg(STG_ID_EX) | stg(STG_EX_MEM);
  localparam logic [4:0] MEM_FLUSH = stg(STG_MEM_WB);
  localparam logic [4:0] BR_FLUSH = stg(STG_IF_ID) | stg(STG_ID_EX);
  localparam logic [4:0] LU_STALL = stg(STG_PC) | stg(STG_IF_ID);
  localparam logic [4:0] LU_FLUSH = stg(STG_ID_EX);
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the ID sources and the EX load destination
module hazard_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] id_reg1_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_i,
  input  logic                  id_reg1_read_i,
  input  logic                  id_reg2_read_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_reg3_i,
  output logic                  load_use_o
);
  assign load_use_o = ex_mem_read_i & ((id_reg1_read_i & (id_reg1_i == ex_reg3_i)) |
                                       (id_reg2_read_i & (id_reg2_i == ex_reg3_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller with dmem handshake FSM; PIPE_HAZARD_CTRL_TIMEOUT_EN adds wait timeout and sticky dmem_err_o
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 15
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_i,
  input  logic                  id_reg1Read_i,
  input  logic                  id_reg2Read_i,
  input  logic                  ex_memRead_i,
  input  logic [REG_ADDR_W-1:0] ex_reg3_i,
  input  logic                  ex_branchTaken_i,
  input  logic                  mem_memRead_i,
  input  logic                  mem_memWrite_i,
  input  logic                  dmem_ack_i,
  output logic                  dmem_req_o,
  output logic [4:0]            stall_o,
  output logic [4:0]            flush_o,
  output logic                  dmem_err_o
);
  logic [1:0] st_q, st_d;
  logic req_q, req_d;
  logic access, mem_stall, load_use, lu_win, tmo;
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_reg1_i      (id_reg1_i),
    .id_reg2_i      (id_reg2_i),
    .id_reg1_read_i (id_reg1Read_i),
    .id_reg2_read_i (id_reg2Read_i),
    .ex_mem_read_i  (ex_memRead_i),
    .ex_reg3_i      (ex_reg3_i),
    .load_use_o     (load_use)
  );
  assign access = mem_memRead_i | mem_memWrite_i;
  // stall in the IDLE cycle that sees the access so the instruction cannot leave MEM before the request
  assign mem_stall = ((st_q == ST_IDLE) & access) | (st_q == ST_WAIT);
  // a taken branch flushes the ID instruction, so its load-use hazard is moot
  assign lu_win = load_use & ~ex_branchTaken_i;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);
  logic [3:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // ack in the timeout cycle wins
  assign tmo = (st_q == ST_WAIT) & ~dmem_ack_i & (cnt_q == CNT_LAST);
  assign cnt_d = (st_q == ST_WAIT) ? cnt_q + 4'd1 : 4'd0;
  assign err_d = err_q | tmo;
  always_ff @(posedge clk_i or negedge rst_i)
    if (rst_i == RST_ACTIVE) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign dmem_err_o = err_q;
`else
  assign tmo = 1'b0;
  assign dmem_err_o = 1'b0;
`endif
  assign st_d = (st_q == ST_IDLE) ? (access ? ST_WAIT : ST_IDLE) :
                (st_q == ST_WAIT) ? ((dmem_ack_i | tmo) ? ST_DONE : ST_WAIT) : ST_IDLE;
  assign req_d = (st_d == ST_WAIT);
  always_ff @(posedge clk_i or negedge rst_i)
    if (rst_i == RST_ACTIVE) begin
      st_q  <= ST_IDLE;
      req_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
    end
  assign dmem_req_o = req_q;
  assign stall_o = (rst_i == RST_ACTIVE) ? 5'd0 :
                   mem_stall ? MEM_STALL : lu_win ? LU_STALL : 5'd0;
  assign flush_o = (rst_i == RST_ACTIVE) ? 5'd0 :
                   mem_stall ? MEM_FLUSH : ex_branchTaken_i ? BR_FLUSH : lu_win ? LU_FLUSH : 5'd0;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a per-cycle behavioural model plus literal expectations
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_i;
  logic [2:0] id_reg1_i, id_reg2_i, ex_reg3_i;
  logic id_reg1Read_i, id_reg2Read_i, ex_memRead_i, ex_branchTaken_i;
  logic mem_memRead_i, mem_memWrite_i, dmem_ack_i;
  logic dmem_req_o, dmem_err_o;
  logic [4:0] stall_o, flush_o;
  int tests = 0;
  int fails = 0;
  logic m_busy, m_cool, m_err;
  int m_waits;
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
    .id_reg1Read_i(id_reg1Read_i), .id_reg2Read_i(id_reg2Read_i),
    .ex_memRead_i(ex_memRead_i), .ex_reg3_i(ex_reg3_i),
    .ex_branchTaken_i(ex_branchTaken_i),
    .mem_memRead_i(mem_memRead_i), .mem_memWrite_i(mem_memWrite_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .stall_o(stall_o), .flush_o(flush_o), .dmem_err_o(dmem_err_o)
  );
  // model: a memory access is either in flight (request out), in its one-cycle cool-down, or absent
  always @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_cool <= 1'b0;
      m_err <= 1'b0;
      m_waits <= 0;
    end else if (m_busy) begin
      m_waits <= m_waits + 1;
      if (dmem_ack_i) begin
        m_busy <= 1'b0;
        m_cool <= 1'b1;
      end
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
      else if (m_waits + 1 == 15) begin
        m_busy <= 1'b0;
        m_cool <= 1'b1;
        m_err <= 1'b1;
      end
`endif
    end else if (m_cool) m_cool <= 1'b0;
    else if (mem_memRead_i || mem_memWrite_i) begin
      m_busy <= 1'b1;
      m_waits <= 0;
    end
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  task automatic model_cmp();
    logic ms, lu;
    logic [4:0] es, ef;
    ms = m_busy || (!m_cool && (mem_memRead_i || mem_memWrite_i));
    lu = ex_memRead_i && ((id_reg1Read_i && id_reg1_i == ex_reg3_i) ||
                          (id_reg2Read_i && id_reg2_i == ex_reg3_i));
    es = 5'b00000;
    ef = 5'b00000;
    if (!rst_i) begin
      es = 5'b00000;
    end else if (ms) begin
      es = 5'b01111;
      ef = 5'b10000;
    end else if (ex_branchTaken_i) begin
      ef = 5'b00110;
    end else if (lu) begin
      es = 5'b00011;
      ef = 5'b00100;
    end
    chk("model_stall", stall_o, es);
    chk("model_flush", flush_o, ef);
    chk("model_req", {4'b0, dmem_req_o}, {4'b0, m_busy});
    chk("model_err", {4'b0, dmem_err_o}, {4'b0, m_err});
  endtask
  task automatic cyc_lit(input string name, input logic [4:0] s, input logic [4:0] f, input logic r);
    @(negedge clk);
    model_cmp();
    chk({name, "_stall"}, stall_o, s);
    chk({name, "_flush"}, flush_o, f);
    chk({name, "_req"}, {4'b0, dmem_req_o}, {4'b0, r});
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    id_reg1_i = 3'd0; id_reg2_i = 3'd0; ex_reg3_i = 3'd0;
    id_reg1Read_i = 1'b0; id_reg2Read_i = 1'b0; ex_memRead_i = 1'b0;
    ex_branchTaken_i = 1'b0; mem_memRead_i = 1'b0; mem_memWrite_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask
  initial begin
    clr();
    rst_i = 1'b0;
    mem_memRead_i = 1'b1;
    ex_branchTaken_i = 1'b1;
    #12;
    chk("rst_stall", stall_o, 5'b00000);
    chk("rst_flush", flush_o, 5'b00000);
    chk("rst_req", {4'b0, dmem_req_o}, 5'b0);
    chk("rst_err", {4'b0, dmem_err_o}, 5'b0);
    clr();
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    cyc_lit("idle", 5'b00000, 5'b00000, 1'b0);
    ex_memRead_i = 1'b1; ex_reg3_i = 3'd3; id_reg2_i = 3'd3; id_reg2Read_i = 1'b1;
    cyc_lit("lu", 5'b00011, 5'b00100, 1'b0);
    ex_memRead_i = 1'b0;
    cyc_lit("lu_end", 5'b00000, 5'b00000, 1'b0);
    clr();
    ex_memRead_i = 1'b1; ex_reg3_i = 3'd0; id_reg1_i = 3'd0; id_reg1Read_i = 1'b1;
    cyc_lit("lu_r0", 5'b00011, 5'b00100, 1'b0);
    id_reg1Read_i = 1'b0;
    cyc_lit("lu_noread", 5'b00000, 5'b00000, 1'b0);
    id_reg1Read_i = 1'b1; id_reg1_i = 3'd5; ex_reg3_i = 3'd4;
    cyc_lit("lu_diff", 5'b00000, 5'b00000, 1'b0);
    clr();
    dmem_ack_i = 1'b1;
    cyc_lit("ack_idle", 5'b00000, 5'b00000, 1'b0);
    clr();
    mem_memRead_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dmem_ack_i = (i == 4);
      cyc_lit("mem", (i < 5) ? 5'b01111 : 5'b00000, (i < 5) ? 5'b10000 : 5'b00000, i >= 1 && i <= 4);
    end
    clr();
    cyc_lit("mem_after", 5'b00000, 5'b00000, 1'b0);
    ex_branchTaken_i = 1'b1; ex_memRead_i = 1'b1; ex_reg3_i = 3'd2; id_reg1_i = 3'd2; id_reg1Read_i = 1'b1;
    cyc_lit("br_lu", 5'b00000, 5'b00110, 1'b0);
    clr();
    mem_memWrite_i = 1'b1; ex_branchTaken_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 2);
      cyc_lit("br_mem", (i < 3) ? 5'b01111 : 5'b00000, (i < 3) ? 5'b10000 : 5'b00110, i == 1 || i == 2);
    end
    clr();
    cyc_lit("br_mem_after", 5'b00000, 5'b00000, 1'b0);
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    mem_memRead_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dmem_ack_i = (i == 15);
      cyc_lit("tmo_ack", (i < 16) ? 5'b01111 : 5'b00000, (i < 16) ? 5'b10000 : 5'b00000, i >= 1 && i <= 15);
    end
    clr();
    chk("tmo_ack_err", {4'b0, dmem_err_o}, 5'b0);
    mem_memRead_i = 1'b1;
    for (int i = 0; i < 17; i++)
      cyc_lit("tmo", (i < 16) ? 5'b01111 : 5'b00000, (i < 16) ? 5'b10000 : 5'b00000, i >= 1 && i <= 15);
    clr();
    chk("tmo_err", {4'b0, dmem_err_o}, 5'b1);
    cyc_lit("tmo_hold", 5'b00000, 5'b00000, 1'b0);
    chk("tmo_err_sticky", {4'b0, dmem_err_o}, 5'b1);
`endif
    mem_memRead_i = 1'b1;
    cyc_lit("ar_idle", 5'b01111, 5'b10000, 1'b0);
    cyc_lit("ar_wait", 5'b01111, 5'b10000, 1'b1);
    #1 rst_i = 1'b0;
    #1;
    chk("ar_stall", stall_o, 5'b00000);
    chk("ar_flush", flush_o, 5'b00000);
    chk("ar_req", {4'b0, dmem_req_o}, 5'b0);
    chk("ar_err", {4'b0, dmem_err_o}, 5'b0);
    mem_memRead_i = 1'b0;
    #1 rst_i = 1'b1;
    cyc_lit("ar_rel", 5'b00000, 5'b00000, 1'b0);
    mem_memRead_i = 1'b1;
    cyc_lit("ar_new", 5'b01111, 5'b10000, 1'b0);
    dmem_ack_i = 1'b1;
    cyc_lit("ar_new_wait", 5'b01111, 5'b10000, 1'b1);
    clr();
    cyc_lit("ar_done", 5'b00000, 5'b00000, 1'b0);
    cyc_lit("end", 5'b00000, 5'b00000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
